buffer_reader: RTL
==================

# buffer_reader

Read-side consumer for the clock-domain-crossing buffer: pops one 16-bit word at a time from the buffer's read port, converts it to five packed BCD digits with a sequential shift-add-3 (double-dabble) engine, and presents the digits to the display multiplexer for a programmable hold time before popping the next word. It sits in the slow display clock domain, opposite the producer FSM that writes Fibonacci and Timer samples into the buffer. It owns the read handshake and paces consumption so every value is visible on the display.

## Interface
- `HOLD_COUNT`, default 500: cycles each converted value is held before the next pop (≥1).
- `TIMEOUT_CYCLES`, default 8: maximum wait for `rd_valid` after a pop. Used only with `BUFFER_READER_TIMEOUT_EN`.

- `clk`  in  1  single clock for the whole block (the buffer's read clock).
- `rst`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  high allows new pops; low finishes the word in flight, then idles.
- `buffer_empty`  in  1  buffer has no words.
- `rd_en`  out  1  one-cycle pop request.
- `rd_valid`  in  1  `rd_data` valid this cycle (response to `rd_en`).
- `rd_data`  in  16  popped word.
- `bcd`  out  20  five BCD digits; [19:16] is the ten-thousands digit, [3:0] the units digit.
- `bcd_valid`  out  1  one-cycle pulse when `bcd` updates.
- `busy`  out  1  high in any state other than IDLE.
- `words_read`  out  16  count of words converted; wraps from 0xFFFF to 0.
- `rd_timeout`  out  1  sticky error flag. Exists only with the macro.

## Operation
FSM states and transitions:
- **IDLE**: if `enable` and not `buffer_empty`, go to POP.
- **POP**: drive `rd_en`=1 for exactly one cycle, then go to WAIT.
- **WAIT**: when `rd_valid`=1, capture `rd_data` into the shift register, clear the BCD accumulator, and go to CONV.
- **CONV**: runs 16 iterations, one per cycle. Each iteration first adds 3 to every BCD nibble ≥5, then shifts {accumulator, shift register} left by 1. After the 16th iteration go to LOAD.
- **LOAD**: register the accumulator to `bcd`, pulse `bcd_valid`, increment `words_read`, reload the hold counter, and go to HOLD.
- **HOLD**: count down HOLD_COUNT cycles, then go to IDLE.

Rules:
- `rd_valid` seen outside WAIT is ignored; the word is discarded and not counted.
- `enable` deasserted mid-flow does not abort the current word. It only blocks the next IDLE→POP transition.
- `buffer_empty` is sampled only in IDLE.
- `bcd` keeps its last value through IDLE and HOLD, so the display never blanks between words.
- Reset mid-operation (`rst`=0) forces IDLE immediately. `bcd`=0, `bcd_valid`=0, `rd_en`=0, `busy`=0, `words_read`=0, `rd_timeout`=0.

## Timing
- All outputs are registered. Reset values are listed under Operation.
- Pop to display, with `rd_valid` one cycle after `rd_en`:
  - POP(1) + WAIT(1) + CONV(16) + LOAD(1) = `bcd_valid` pulse 19 cycles after the `rd_en` cycle.
- Full period per word = 19 + HOLD_COUNT + 1 (IDLE) cycles, with `buffer_empty`=0 throughout.
- `rd_en` is never high in two consecutive cycles. At most one word is outstanding.
- `words_read` and `bcd` update in the same cycle as `bcd_valid`.

## Configuration
`BUFFER_READER_TIMEOUT_EN` defined:
- WAIT counts cycles from entry.
- If `rd_valid` has not arrived after TIMEOUT_CYCLES cycles, go to IDLE, set `rd_timeout`=1, and leave `words_read` and `bcd` unchanged.
- `rd_timeout` clears only on reset.

Macro not defined:
- No `rd_timeout` port.
- WAIT waits indefinitely for `rd_valid`.

## Test plan
1. Reset values and empty buffer:
   - Stimulus: hold `rst`=0, then release with `buffer_empty`=1.
   - Required: all outputs 0; `rd_en` stays 0 and `busy`=0 for 1000 cycles.
2. Single word:
   - Stimulus: `rd_data`=0x3039, `rd_valid` one cycle after `rd_en`.
   - Required: `bcd`=0x12345, `bcd_valid` pulse 19 cycles after `rd_en`, `words_read`=1.
3. Value boundaries:
   - Stimulus: words 0x0000, 0xFFFF, 0x0009.
   - Required: `bcd`=0x00000, 0x65535, 0x00009 in order; successive `bcd_valid` pulses spaced 20+HOLD_COUNT cycles apart.
4. `enable` drop and reset mid-conversion:
   - Stimulus: deassert `enable` during CONV.
   - Required: the current word completes, then no further `rd_en`.
   - Stimulus: apply `rst`=0 during CONV.
   - Required: `bcd`=0 and state IDLE in the same cycle.
5. Timeout, with macro defined and TIMEOUT_CYCLES=8:
   - Stimulus: never assert `rd_valid`.
   - Required: return to IDLE after 8 WAIT cycles, `rd_timeout`=1, `words_read` unchanged.
   - Without the macro, the same stimulus leaves the FSM in WAIT indefinitely.
6. Counter wrap:
   - Stimulus: preload or run to `words_read`=0xFFFF, then convert one more word.
   - Required: `words_read`=0x0000.

Source files
------------

// File: rtl/buffer_reader.sv
// buffer_reader: pops 16-bit words, converts them to 5-digit BCD via double-dabble, holds each for display.
// Optional macro BUFFER_READER_TIMEOUT_EN adds a bounded WAIT with sticky rd_timeout.
module buffer_reader #(
    parameter int HOLD_COUNT     = 500,
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        buffer_empty,
    output logic        rd_en,
    input  logic        rd_valid,
    input  logic [15:0] rd_data,
    output logic [19:0] bcd,
    output logic        bcd_valid,
    output logic        busy,
    output logic [15:0] words_read
`ifdef BUFFER_READER_TIMEOUT_EN
    ,
    output logic        rd_timeout
`endif
);
    localparam int HW = $clog2(HOLD_COUNT + 1);
    typedef enum logic [2:0] {IDLE, POP, WAIT, CONV, LOAD, HOLD} state_t;
    state_t state;
    logic [19:0] acc, adj;
    logic [15:0] sr;
    logic [3:0] cnt;
    logic [HW-1:0] hold;
`ifdef BUFFER_READER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;
`endif
    for (genvar i = 0; i < 5; i++) begin : g_adj
        assign adj[4*i+:4] = acc[4*i+:4] > 4'd4 ? acc[4*i+:4] + 4'd3 : acc[4*i+:4];
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            rd_en      <= 1'b0;
            bcd        <= '0;
            bcd_valid  <= 1'b0;
            busy       <= 1'b0;
            words_read <= '0;
            acc        <= '0;
            sr         <= '0;
            cnt        <= '0;
            hold       <= '0;
`ifdef BUFFER_READER_TIMEOUT_EN
            tcnt       <= '0;
            rd_timeout <= 1'b0;
`endif
        end else begin
            rd_en     <= 1'b0;
            bcd_valid <= 1'b0;
            case (state)
                IDLE: if (enable && !buffer_empty) begin
                    state <= POP;
                    rd_en <= 1'b1;
                    busy  <= 1'b1;
                end
                POP: begin
                    state <= WAIT;
`ifdef BUFFER_READER_TIMEOUT_EN
                    tcnt  <= '0;
`endif
                end
                WAIT: if (rd_valid) begin
                    sr    <= rd_data;
                    acc   <= '0;
                    cnt   <= '0;
                    state <= CONV;
                end
`ifdef BUFFER_READER_TIMEOUT_EN
                else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    rd_timeout <= 1'b1;
                end else tcnt <= tcnt + 1'b1;
`endif
                CONV: begin
                    // adj[19] is always 0 for 16-bit inputs, so it is dropped by the shift
                    {acc, sr} <= {adj[18:0], sr, 1'b0};
                    cnt       <= cnt + 1'b1;
                    if (cnt == 4'd15) state <= LOAD;
                end
                LOAD: begin
                    bcd        <= acc;
                    bcd_valid  <= 1'b1;
                    words_read <= words_read + 1'b1;
                    hold       <= HW'(HOLD_COUNT);
                    state      <= HOLD;
                end
                HOLD: if (hold == HW'(1)) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else hold <= hold - 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
